// File: rtl/sobel_window_gen_pkg.sv
// Shared constants for the Sobel window path (package sobel_pkg).
// Holds the default geometry, the coordinate widths and a counter-width helper.
package sobel_pkg;

  localparam int DEF_PIX_W      = 8;
  localparam int DEF_IMG_WIDTH  = 640;
  localparam int DEF_IMG_HEIGHT = 480;

  localparam int COL_W = $clog2(DEF_IMG_WIDTH);
  localparam int ROW_W = $clog2(DEF_IMG_HEIGHT);

  function automatic int coord_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/sobel_window_gen_if.sv
// Pixel stream in / 3x3 window out bundle between the video source and sobel_window_gen.
interface sobel_window_gen_if
  import sobel_pkg::*;
#(
  parameter int PIX_W = DEF_PIX_W
);
  logic             in_valid;
  logic             in_sof;
  logic [PIX_W-1:0] in_pixel;
  logic [PIX_W-1:0] pixel0, pixel1, pixel2;
  logic [PIX_W-1:0] pixel3, pixel4, pixel5;
  logic [PIX_W-1:0] pixel6, pixel7, pixel8;
  logic             out_valid;
  logic             frame_done;

  modport master (
    output in_valid, in_sof, in_pixel,
    input  pixel0, pixel1, pixel2, pixel3, pixel4, pixel5, pixel6, pixel7, pixel8,
    input  out_valid, frame_done
  );

  modport slave (
    input  in_valid, in_sof, in_pixel,
    output pixel0, pixel1, pixel2, pixel3, pixel4, pixel5, pixel6, pixel7, pixel8,
    output out_valid, frame_done
  );
endinterface

// File: rtl/sobel_window_gen_line_buffer.sv
// One image line of storage: synchronous write plus a registered look-ahead read.
module sobel_line_buffer #(
  parameter int DEPTH = 640,
  parameter int WIDTH = 8,
  parameter int AW    = 10
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data_q
);
  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[wr_addr] <= wr_data;
    rd_data_q <= mem[rd_addr];
  end
endmodule

// File: rtl/sobel_window_gen.sv
// Streaming 3x3 window generator feeding sobel_conv (two line buffers + 3x3 shift window).
// Define SOBEL_WIN_OUT_REG_EN to add one output register stage (latency 2).
module sobel_window_gen
  import sobel_pkg::*;
#(
  parameter int IMG_WIDTH  = DEF_IMG_WIDTH,
  parameter int IMG_HEIGHT = DEF_IMG_HEIGHT,
  parameter int PIX_W      = DEF_PIX_W
) (
  input logic               clk,
  input logic               reset,
  sobel_window_gen_if.slave bus
);
  localparam int CW = coord_w(IMG_WIDTH);
  localparam int RW = coord_w(IMG_HEIGHT);
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);
  localparam logic [CW-1:0] COL_TWO  = CW'(2);
  localparam logic [RW-1:0] ROW_TWO  = RW'(2);

  logic [CW-1:0]    col_q, col_d, col_cur;
  logic [RW-1:0]    row_q, row_d, row_cur;
  logic [PIX_W-1:0] win_q [9];
  logic [PIX_W-1:0] win_d [9];
  logic             out_valid_q, out_valid_d;
  logic             frame_done_q, frame_done_d;
  logic [PIX_W-1:0] lb0_rd, lb1_rd;
  logic [CW-1:0]    lb_rd_addr;
  logic             lb_we;

  always_comb begin
    col_cur      = bus.in_sof ? '0 : col_q;
    row_cur      = bus.in_sof ? '0 : row_q;
    col_d        = col_q;
    row_d        = row_q;
    win_d        = win_q;
    out_valid_d  = 1'b0;
    frame_done_d = 1'b0;
    if (bus.in_valid) begin
      out_valid_d = (row_cur >= ROW_TWO) && (col_cur >= COL_TWO);
      if (col_cur == COL_LAST) begin
        col_d = '0;
        if (row_cur == ROW_LAST) begin
          row_d        = '0;
          frame_done_d = 1'b1;
        end else begin
          row_d = row_cur + 1'b1;
        end
      end else begin
        col_d = col_cur + 1'b1;
        row_d = row_cur;
      end
      for (int unsigned k = 0; k < 3; k++) begin
        win_d[3*k]   = win_q[3*k+1];
        win_d[3*k+1] = win_q[3*k+2];
      end
      win_d[2] = lb1_rd;
      win_d[5] = lb0_rd;
      win_d[8] = bus.in_pixel;
    end
  end

  // The buffers prefetch the column of the next accept so read data is ready in
  // the accept cycle. An in_sof accept uses a stale prefetch, but that only
  // lands in rows 0/1 of the new frame, which are never part of a valid window.
  assign lb_we      = bus.in_valid && !reset;
  assign lb_rd_addr = reset ? '0 : col_d;

  sobel_line_buffer #(.DEPTH(IMG_WIDTH), .WIDTH(PIX_W), .AW(CW)) u_lb0 (
    .clk       (clk),
    .we        (lb_we),
    .wr_addr   (col_cur),
    .wr_data   (bus.in_pixel),
    .rd_addr   (lb_rd_addr),
    .rd_data_q (lb0_rd)
  );

  sobel_line_buffer #(.DEPTH(IMG_WIDTH), .WIDTH(PIX_W), .AW(CW)) u_lb1 (
    .clk       (clk),
    .we        (lb_we),
    .wr_addr   (col_cur),
    .wr_data   (lb0_rd),
    .rd_addr   (lb_rd_addr),
    .rd_data_q (lb1_rd)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      col_q        <= '0;
      row_q        <= '0;
      out_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
      for (int unsigned k = 0; k < 9; k++) win_q[k] <= '0;
    end else begin
      col_q        <= col_d;
      row_q        <= row_d;
      out_valid_q  <= out_valid_d;
      frame_done_q <= frame_done_d;
      win_q        <= win_d;
    end
  end

  logic [PIX_W-1:0] pix_o [9];
  logic             valid_o, done_o;

`ifdef SOBEL_WIN_OUT_REG_EN
  logic [PIX_W-1:0] win_r_q [9];
  logic             out_valid_r_q, frame_done_r_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid_r_q  <= 1'b0;
      frame_done_r_q <= 1'b0;
      for (int unsigned k = 0; k < 9; k++) win_r_q[k] <= '0;
    end else begin
      out_valid_r_q  <= out_valid_q;
      frame_done_r_q <= frame_done_q;
      win_r_q        <= win_q;
    end
  end

  always_comb begin
    pix_o   = win_r_q;
    valid_o = out_valid_r_q;
    done_o  = frame_done_r_q;
  end
`else
  always_comb begin
    pix_o   = win_q;
    valid_o = out_valid_q;
    done_o  = frame_done_q;
  end
`endif

  assign bus.pixel0     = pix_o[0];
  assign bus.pixel1     = pix_o[1];
  assign bus.pixel2     = pix_o[2];
  assign bus.pixel3     = pix_o[3];
  assign bus.pixel4     = pix_o[4];
  assign bus.pixel5     = pix_o[5];
  assign bus.pixel6     = pix_o[6];
  assign bus.pixel7     = pix_o[7];
  assign bus.pixel8     = pix_o[8];
  assign bus.out_valid  = valid_o;
  assign bus.frame_done = done_o;
endmodule

// File: tb/tb_sobel_window_gen.sv
// Self-checking bench for sobel_window_gen on a 4x4 image, using a frame-image reference model.
module tb_sobel_window_gen;
  import sobel_pkg::*;

  localparam int W  = 4;
  localparam int H  = 4;
  localparam int PW = 8;
`ifdef SOBEL_WIN_OUT_REG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  typedef struct packed {
    logic            chk;
    logic            valid;
    logic            fd;
    logic            known;
    logic            hold;
    logic [8:0][7:0] win;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  sobel_window_gen_if #(.PIX_W(PW)) bus ();

  sobel_window_gen #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .PIX_W(PW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks   = 0;
  int failures = 0;

  exp_t            pipe [2];
  logic [7:0]      img [H][W];
  int              mrow, mcol;
  int              acc_cnt, first_acc, dut_nvalid, dut_nfd, mdl_nvalid, mdl_nfd;
  logic [8:0][7:0] mdl_first_win, mdl_last_win, prev_win, cur_win;
  exp_t            ce;

  task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Reference: record the current frame as an image and cut windows out of it.
  task automatic step(input bit v, input bit sof, input logic [7:0] pix, input bit rst);
    exp_t e;
    @(negedge clk);
    reset        = rst;
    bus.in_valid = v;
    bus.in_sof   = sof;
    bus.in_pixel = pix;
    @(posedge clk);
    #1;
    if (rst) begin
      mrow = 0;
      mcol = 0;
      e = '0;
      e.chk = 1'b1;
      e.known = 1'b1;
      pipe[0] = e;
      pipe[1] = e;
    end else if (v) begin
      if (sof) begin
        mrow = 0;
        mcol = 0;
      end
      img[mrow][mcol] = pix;
      acc_cnt++;
      e = '0;
      e.chk   = 1'b1;
      e.valid = (mrow >= 2) && (mcol >= 2);
      e.fd    = (mrow == H - 1) && (mcol == W - 1);
      if (e.valid) begin
        e.known = 1'b1;
        for (int i = 0; i < 9; i++) e.win[i] = img[mrow - 2 + i / 3][mcol - 2 + i % 3];
        if (mdl_nvalid == 0) mdl_first_win = e.win;
        mdl_last_win = e.win;
        mdl_nvalid++;
      end
      if (e.fd) mdl_nfd++;
      mcol++;
      if (mcol == W) begin
        mcol = 0;
        mrow++;
        if (mrow == H) mrow = 0;
      end
      pipe[1] = pipe[0];
      pipe[0] = e;
    end else begin
      e = pipe[0];
      e.valid = 1'b0;
      e.fd    = 1'b0;
      e.hold  = 1'b1;
      pipe[1] = pipe[0];
      pipe[0] = e;
    end
  endtask

  task automatic mark();
    acc_cnt    = 0;
    first_acc  = -1;
    dut_nvalid = 0;
    dut_nfd    = 0;
    mdl_nvalid = 0;
    mdl_nfd    = 0;
  endtask

  task automatic send_pixels(input int base, input bit sof_first, input bit gaps, input int count);
    for (int n = 0; n < count; n++) begin
      step(1'b1, sof_first && (n == 0), 8'(base + 16 * (n / W) + (n % W)), 1'b0);
      if (gaps) step(1'b0, 1'b0, 8'h00, 1'b0);
    end
  endtask

  task automatic drain();
    for (int n = 0; n < 3; n++) step(1'b0, 1'b0, 8'h00, 1'b0);
  endtask

  always @(negedge clk) begin
    ce = pipe[LAT-1];
    cur_win = {bus.pixel8, bus.pixel7, bus.pixel6, bus.pixel5, bus.pixel4,
               bus.pixel3, bus.pixel2, bus.pixel1, bus.pixel0};
    if (ce.chk) begin
      chk("out_valid", 72'(bus.out_valid), 72'(ce.valid));
      chk("frame_done", 72'(bus.frame_done), 72'(ce.fd));
      if (ce.known) chk("window", 72'(cur_win), 72'(ce.win));
      else if (ce.hold) chk("window_hold", 72'(cur_win), 72'(prev_win));
      if (bus.out_valid === 1'b1) begin
        dut_nvalid++;
        if (first_acc < 0) first_acc = acc_cnt;
      end
      if (bus.frame_done === 1'b1) dut_nfd++;
    end
    prev_win = cur_win;
  end

  initial begin
    pipe[0] = '0;
    pipe[1] = '0;
    reset = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_sof   = 1'b0;
    bus.in_pixel = '0;
    mrow = 0;
    mcol = 0;
    mark();
    step(1'b0, 1'b0, 8'h00, 1'b1);
    step(1'b0, 1'b0, 8'h00, 1'b1);
    step(1'b0, 1'b0, 8'h00, 1'b0);

    // Continuous frame
    mark();
    send_pixels(0, 1'b1, 1'b0, W * H);
    drain();
    chk("s1_first_acc", 72'(first_acc), 72'(10 + LAT));
    chk("s1_nvalid", 72'(dut_nvalid), 72'd4);
    chk("s1_nfd", 72'(dut_nfd), 72'd1);
    chk("s1_model_first", 72'(mdl_first_win), 72'h22_21_20_12_11_10_02_01_00);
    chk("s1_model_last", 72'(mdl_last_win), 72'h33_32_31_23_22_21_13_12_11);
    chk("s1_model_nfd", 72'(mdl_nfd), 72'd1);

    // in_valid toggled 1-0-1
    mark();
    send_pixels(0, 1'b1, 1'b1, W * H);
    drain();
    chk("s2_nvalid", 72'(dut_nvalid), 72'd4);
    chk("s2_nfd", 72'(dut_nfd), 72'd1);
    chk("s2_model_first", 72'(mdl_first_win), 72'h22_21_20_12_11_10_02_01_00);

    // Back-to-back frames
    mark();
    send_pixels(0, 1'b1, 1'b0, W * H);
    mdl_nvalid = 0;
    send_pixels(8'h80, 1'b1, 1'b0, W * H);
    drain();
    chk("s3_nvalid", 72'(dut_nvalid), 72'd8);
    chk("s3_nfd", 72'(dut_nfd), 72'd2);
    chk("s3_model_first_f2", 72'(mdl_first_win), 72'hA2_A1_A0_92_91_90_82_81_80);

    // in_sof at frame-1 pixel (1,2)
    send_pixels(0, 1'b1, 1'b0, 6);
    mark();
    send_pixels(8'h40, 1'b1, 1'b0, W * H);
    drain();
    chk("s4_first_acc", 72'(first_acc), 72'(10 + LAT));
    chk("s4_nvalid", 72'(dut_nvalid), 72'd4);
    chk("s4_nfd", 72'(dut_nfd), 72'd1);
    chk("s4_model_first", 72'(mdl_first_win), 72'h62_61_60_52_51_50_42_41_40);

    // Reset pulsed at pixel (2,3)
    send_pixels(0, 1'b1, 1'b0, 11);
    step(1'b1, 1'b0, 8'h23, 1'b1);
    mark();
    send_pixels(0, 1'b0, 1'b0, W * H);
    drain();
    chk("s5_first_acc", 72'(first_acc), 72'(10 + LAT));
    chk("s5_nvalid", 72'(dut_nvalid), 72'd4);
    chk("s5_nfd", 72'(dut_nfd), 72'd1);
    chk("s5_model_first", 72'(mdl_first_win), 72'h22_21_20_12_11_10_02_01_00);
    chk("s5_model_last", 72'(mdl_last_win), 72'h33_32_31_23_22_21_13_12_11);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
